// File: rtl/ahb_sram.sv
// AHB-Lite SRAM responder with byte-lane writes, wait states and ERROR responses.
// Optional write protection input enabled by defining AHB_SRAM_WPROT_EN.
module ahb_sram #(
    parameter int ADDR_WIDTH  = 12,
    parameter int WAIT_STATES = 0
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        HSEL,
    input  logic [31:0] HADDR,
    input  logic [1:0]  HTRANS,
    input  logic [2:0]  HSIZE,
    input  logic        HWRITE,
    input  logic [31:0] HWDATA,
    input  logic        HREADY,
`ifdef AHB_SRAM_WPROT_EN
    input  logic        i_wprot,
`endif
    output logic        HREADYOUT,
    output logic        HRESP,
    output logic [31:0] HRDATA
);

    localparam int IW    = ADDR_WIDTH - 2;
    localparam int DEPTH = 2 ** IW;
    localparam logic [3:0] WS_INIT =
        4'((WAIT_STATES > 0) ? WAIT_STATES - 1 : 0);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WAIT,
        ST_DATA,
        ST_ERR1,
        ST_ERR2
    } state_t;

    state_t state;
    state_t next_state;

    logic [31:0]   mem [DEPTH];
    logic [3:0]    cnt;
    logic [IW-1:0] a_idx;
    logic [3:0]    a_lanes;
    logic          a_write;

    logic          can_take;
    logic          accept;
    logic          bad;
    logic          wr_commit;
    logic          rd_now;
    logic [IW-1:0] rd_idx;
    logic [31:0]   rd_word;
    logic          unused_bits;

    // Upper address bits alias onto the array; HTRANS[0] only splits NONSEQ/SEQ.
    assign unused_bits = ^{HADDR[31:ADDR_WIDTH], HTRANS[0]};

    function automatic logic [3:0] lane_mask(
        input logic [2:0] size,
        input logic [1:0] off
    );
        logic [3:0] m;
        case (size)
            3'd0:    m = 4'b0001 << off;
            3'd1:    m = off[1] ? 4'b1100 : 4'b0011;
            default: m = 4'b1111;
        endcase
        return m;
    endfunction

    // Address-phase decode: acceptance and legality of the presented transfer.
    always_comb begin
        can_take = (state == ST_IDLE) || (state == ST_DATA)
                || (state == ST_ERR2);
        accept = can_take && HSEL && HREADY && HTRANS[1];
        bad = 1'b0;
        if (HSIZE > 3'd2) begin
            bad = 1'b1;
        end else if (HSIZE == 3'd1 && HADDR[0]) begin
            bad = 1'b1;
        end else if (HSIZE == 3'd2 && HADDR[1:0] != 2'b00) begin
            bad = 1'b1;
        end
`ifdef AHB_SRAM_WPROT_EN
        if (HWRITE && i_wprot) begin
            bad = 1'b1;
        end
`endif
    end

    // Next-state and response outputs; responses derive from the state alone.
    always_comb begin
        next_state = state;
        HREADYOUT  = 1'b1;
        HRESP      = 1'b0;
        case (state)
            ST_IDLE, ST_DATA, ST_ERR2: begin
                HRESP = (state == ST_ERR2);
                if (accept) begin
                    if (bad) begin
                        next_state = ST_ERR1;
                    end else if (WAIT_STATES > 0) begin
                        next_state = ST_WAIT;
                    end else begin
                        next_state = ST_DATA;
                    end
                end else begin
                    next_state = ST_IDLE;
                end
            end
            ST_WAIT: begin
                HREADYOUT = 1'b0;
                if (cnt == 4'd0) begin
                    next_state = ST_DATA;
                end
            end
            ST_ERR1: begin
                HREADYOUT  = 1'b0;
                HRESP      = 1'b1;
                next_state = ST_ERR2;
            end
            default: next_state = ST_IDLE;
        endcase
    end

    // State register and latched address-phase information.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state   <= ST_IDLE;
            cnt     <= 4'd0;
            a_idx   <= '0;
            a_lanes <= 4'd0;
            a_write <= 1'b0;
        end else begin
            state <= next_state;
            if (accept) begin
                a_idx   <= HADDR[ADDR_WIDTH-1:2];
                a_lanes <= lane_mask(HSIZE, HADDR[1:0]);
                a_write <= HWRITE && !bad;
                cnt     <= WS_INIT;
            end else if (state == ST_WAIT && cnt != 4'd0) begin
                cnt <= cnt - 4'd1;
            end
        end
    end

    // A write lands at the end of its data phase unless reset cuts it off.
    assign wr_commit = (state == ST_DATA) && a_write && !i_reset;

    // Read launches at acceptance (no waits) or on the final wait cycle.
    assign rd_now = (accept && !bad && !HWRITE && (WAIT_STATES == 0))
                 || (state == ST_WAIT && cnt == 4'd0 && !a_write);
    assign rd_idx = accept ? HADDR[ADDR_WIDTH-1:2] : a_idx;

    // Merge in the lanes of a write finishing this cycle to the same word.
    always_comb begin
        rd_word = mem[rd_idx];
        if (wr_commit && a_idx == rd_idx) begin
            for (int b = 0; b < 4; b++) begin
                if (a_lanes[b]) begin
                    rd_word[8*b +: 8] = HWDATA[8*b +: 8];
                end
            end
        end
    end

    // Byte-lane write into the array; contents survive reset.
    always_ff @(posedge i_clk) begin
        if (wr_commit) begin
            for (int b = 0; b < 4; b++) begin
                if (a_lanes[b]) begin
                    mem[a_idx][8*b +: 8] <= HWDATA[8*b +: 8];
                end
            end
        end
    end

    // Read data register, held until the next read is launched.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            HRDATA <= 32'd0;
        end else if (rd_now) begin
            HRDATA <= rd_word;
        end
    end

endmodule
